// File: rtl/systolic_ctrl_n_pkg.sv
// Shared types and constants for the systolic array controller:
// FSM state encoding, end-of-program marker and padding address helper.
package systolic_ctrl_n_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int KW = 5;
    localparam int CW = 6;
    localparam logic [KW-1:0] K_END = '0;

    // Address whose memory location holds zero; used to pad rows/columns.
    function automatic logic [31:0] pad_addr(input int aw);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < aw && i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/systolic_ctrl_n_addr_gen.sv
// One row/column read address: base + idx*K + cnt while feeding,
// the padding location otherwise.
module sa_addr_gen
    import systolic_ctrl_n_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic          i_en,
    input  logic [AW-1:0] i_base,
    input  logic [KW-1:0] i_k,
    input  logic [CW-1:0] i_cnt,
    input  logic [2:0]    i_idx,
    output logic [AW-1:0] o_addr
);

    localparam int XW = AW + 3;

    logic [XW-1:0] w_sum;
    logic [AW-1:0] w_pad;

    assign w_pad  = AW'(pad_addr(AW));
    assign w_sum  = XW'(i_base) + XW'(i_idx) * XW'(i_k) + XW'(i_cnt);
    assign o_addr = i_en ? w_sum[AW-1:0] : w_pad;

endmodule

// File: rtl/systolic_ctrl_n.sv
// Program-driven controller for an N x N output-stationary systolic array:
// fetches K per job, streams operand addresses, sequences diagonal enables.
module systolic_ctrl_n
    import systolic_ctrl_n_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 7,
    parameter int PW = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [PW-1:0]     o_instr_addr,
    input  logic [KW-1:0]     i_instr_data,
    output logic              o_rd_en,
    output logic [N*AW-1:0]   o_a_addr,
    output logic [N*AW-1:0]   o_b_addr,
    output logic [2*N-2:0]    o_pe_en,
    output logic              o_pe_clr,
    output logic              o_c_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int XW     = AW + 3;
    localparam int STAGES = 2 * N - 1;
    localparam logic [PW-1:0] PC_MAX = '1;

    if (N < 2 || N > 8 || DW < 1) begin : g_param_chk
        $error("systolic_ctrl_n: N must be within 2..8 and DW positive");
    end

    state_t            r_state;
    logic [PW-1:0]     r_pc;
    logic [AW-1:0]     r_base;
    logic [KW-1:0]     r_k;
    logic [CW-1:0]     r_cnt;
    logic              r_rd_en;
    logic              r_c_wr_en;
    logic              r_pe_clr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [STAGES-1:0] r_vld_pipe;

    logic [AW-1:0]          w_pad;
    logic [XW-1:0]          w_nk_new;
    logic [XW-1:0]          w_nk;
    logic                   w_ovf;
    logic                   w_feed_last;
    logic                   w_drain_last;
    logic [N-1:0][AW-1:0]   w_a_addr;
    logic [N-1:0][AW-1:0]   w_b_addr;

    assign w_pad        = AW'(pad_addr(AW));
    assign w_nk_new     = XW'(N) * XW'(i_instr_data);
    assign w_nk         = XW'(N) * XW'(r_k);
    assign w_ovf        = (XW'(r_base) + w_nk_new) > XW'(w_pad);
    assign w_feed_last  = (r_cnt == CW'(r_k) - CW'(1));
    // Leaves DRAIN on the edge where cnt becomes K+2N-1: last diagonal just went low.
    assign w_drain_last = (r_cnt == CW'(r_k) + CW'(2 * N - 2));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_base    <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_rd_en   <= 1'b0;
            r_c_wr_en <= 1'b0;
            r_pe_clr  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_c_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_base  <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_instr_data == K_END) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_ovf) begin
                        r_err <= 1'b1;
                        if (r_pc == PC_MAX) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc    <= r_pc + PW'(1);
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_k      <= i_instr_data;
                        r_cnt    <= '0;
                        r_pe_clr <= 1'b0;
                        r_rd_en  <= 1'b1;
                        r_state  <= S_FEED;
                    end
                end
                S_FEED: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_feed_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_drain_last) begin
                        r_c_wr_en <= 1'b1;
                        r_pe_clr  <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_base <= r_base + w_nk[AW-1:0];
                    if (r_pc == PC_MAX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + PW'(1);
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Diagonal d fires d+1 cycles after the matching read was issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[STAGES-2:0], r_rd_en};
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        sa_addr_gen #(.AW(AW)) u_a_gen (
            .i_en   (r_rd_en),
            .i_base (r_base),
            .i_k    (r_k),
            .i_cnt  (r_cnt),
            .i_idx  (3'(g)),
            .o_addr (w_a_addr[g])
        );
        sa_addr_gen #(.AW(AW)) u_b_gen (
            .i_en   (r_rd_en),
            .i_base (r_base),
            .i_k    (r_k),
            .i_cnt  (r_cnt),
            .i_idx  (3'(g)),
            .o_addr (w_b_addr[g])
        );
    end

    assign o_instr_addr = r_pc;
    assign o_rd_en      = r_rd_en;
    assign o_a_addr     = w_a_addr;
    assign o_b_addr     = w_b_addr;
    assign o_pe_en      = r_vld_pipe;
    assign o_pe_clr     = r_pe_clr;
    assign o_c_wr_en    = r_c_wr_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_systolic_ctrl_n.sv
// Directed bench for systolic_ctrl_n: program memory model, negedge monitor,
// one task per scenario with hand-computed expectations.
module tb_systolic_ctrl_n;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int PW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PW-1:0]     instr_addr;
    logic [4:0]        instr_data;
    logic              rd_en;
    logic [N*AW-1:0]   a_addr;
    logic [N*AW-1:0]   b_addr;
    logic [2*N-2:0]    pe_en;
    logic              pe_clr, c_wr_en, busy, done, err;

    logic [4:0] prog [0:15];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int a0_q[$], a1_q[$], b3_q[$], rdc_q[$], wrc_q[$], pe0c_q[$];
    int pe6_n = 0, pe_any = 0, clr_bad = 0, pad_bad = 0;

    always #5 clk = ~clk;

    systolic_ctrl_n #(.N(N), .DW(DW), .AW(AW), .PW(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_instr_addr(instr_addr), .i_instr_data(instr_data),
        .o_rd_en(rd_en), .o_a_addr(a_addr), .o_b_addr(b_addr),
        .o_pe_en(pe_en), .o_pe_clr(pe_clr), .o_c_wr_en(c_wr_en),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always @(posedge clk) instr_data <= prog[instr_addr];

    always @(negedge clk) begin
        cyc++;
        if (rd_en) begin
            a0_q.push_back(int'(a_addr[0*AW +: AW]));
            a1_q.push_back(int'(a_addr[1*AW +: AW]));
            b3_q.push_back(int'(b_addr[3*AW +: AW]));
            rdc_q.push_back(cyc);
            if (pe_clr) clr_bad++;
        end else if (a_addr != '1 || b_addr != '1) pad_bad++;
        if (pe_en[0]) pe0c_q.push_back(cyc);
        if (pe_en[2*N-2]) pe6_n++;
        if (pe_en != '0) pe_any++;
        if (c_wr_en) wrc_q.push_back(cyc);
    end

    task automatic set_prog(input logic [4:0] p0, p1, p2, p3);
        for (int i = 0; i < 16; i++) prog[i] = 5'd0;
        prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s_timeout: done never rose", nm); end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (instr_addr !== 4'd0) begin n_bad++; $display("FAIL rst_pc: got %0d want 0", instr_addr); end
        n_cmp++; if ({rd_en, c_wr_en, busy, done, err} !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 00000", {rd_en, c_wr_en, busy, done, err}); end
        n_cmp++; if (pe_clr !== 1'b1) begin n_bad++; $display("FAIL rst_pe_clr: got %b want 1", pe_clr); end
        n_cmp++; if (pe_en !== '0) begin n_bad++; $display("FAIL rst_pe_en: got %h want 0", pe_en); end
        n_cmp++; if (a_addr !== {N*AW{1'b1}} || b_addr !== {N*AW{1'b1}}) begin n_bad++; $display("FAIL rst_addr: got %h/%h want all ones", a_addr, b_addr); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL idle_hold: busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_single;
        int s_rd = rdc_q.size(), s_wr = wrc_q.size(), s_pe0 = pe0c_q.size();
        int s_pe6 = pe6_n, s_clr = clr_bad, s_pad = pad_bad;
        set_prog(5'd4, 5'd0, 5'd0, 5'd0);
        pulse_start();
        wait_done("single");
        n_cmp++; if (rdc_q.size() - s_rd != 4) begin n_bad++; $display("FAIL single_feed_len: got %0d want 4", rdc_q.size() - s_rd); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a1_q[s_rd+i] != 4 + i) begin n_bad++; $display("FAIL single_a1[%0d]: got %0d want %0d", i, a1_q[s_rd+i], 4 + i); end
        end
        n_cmp++; if (b3_q[s_rd] != 12) begin n_bad++; $display("FAIL single_b3: got %0d want 12", b3_q[s_rd]); end
        n_cmp++; if (pe6_n - s_pe6 != 4) begin n_bad++; $display("FAIL single_pe6: got %0d want 4", pe6_n - s_pe6); end
        n_cmp++; if (wrc_q.size() - s_wr != 1) begin n_bad++; $display("FAIL single_wr: got %0d want 1", wrc_q.size() - s_wr); end
        n_cmp++; if (pe0c_q[s_pe0] - rdc_q[s_rd] != 1) begin n_bad++; $display("FAIL single_pe0_lat: got %0d want 1", pe0c_q[s_pe0] - rdc_q[s_rd]); end
        n_cmp++; if (wrc_q[s_wr] - rdc_q[s_rd] != 11) begin n_bad++; $display("FAIL single_wr_lat: got %0d want 11", wrc_q[s_wr] - rdc_q[s_rd]); end
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_end: err %b busy %b want 0 0", err, busy); end
        n_cmp++; if (clr_bad != s_clr || pad_bad != s_pad) begin n_bad++; $display("FAIL single_clr_pad: clr %0d pad %0d want 0 0", clr_bad - s_clr, pad_bad - s_pad); end
    endtask

    task automatic test_two_jobs;
        int exp_a0[6] = '{0, 1, 2, 3, 16, 17};
        int s_rd = rdc_q.size(), s_wr = wrc_q.size();
        set_prog(5'd4, 5'd2, 5'd0, 5'd0);
        pulse_start();
        wait_done("two");
        n_cmp++; if (rdc_q.size() - s_rd != 6) begin n_bad++; $display("FAIL two_feed_len: got %0d want 6", rdc_q.size() - s_rd); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (a0_q[s_rd+i] != exp_a0[i]) begin n_bad++; $display("FAIL two_a0[%0d]: got %0d want %0d", i, a0_q[s_rd+i], exp_a0[i]); end
            end
            n_cmp++; if (b3_q[s_rd+4] != 22 || b3_q[s_rd+5] != 23) begin n_bad++; $display("FAIL two_b3: got %0d,%0d want 22,23", b3_q[s_rd+4], b3_q[s_rd+5]); end
        end
        n_cmp++; if (wrc_q.size() - s_wr != 2) begin n_bad++; $display("FAIL two_wr: got %0d want 2", wrc_q.size() - s_wr); end
    endtask

    // Job 2 overflows (base 64 + 4*16 = 128); job 3 proceeds from base 64.
    task automatic test_overflow;
        int s_rd = rdc_q.size(), s_wr = wrc_q.size();
        set_prog(5'd16, 5'd16, 5'd8, 5'd0);
        pulse_start();
        wait_done("ovf");
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", err); end
        n_cmp++; if (wrc_q.size() - s_wr != 2) begin n_bad++; $display("FAIL ovf_wr: got %0d want 2", wrc_q.size() - s_wr); end
        n_cmp++; if (rdc_q.size() - s_rd != 24) begin n_bad++; $display("FAIL ovf_feed_len: got %0d want 24", rdc_q.size() - s_rd); end
        else begin
            n_cmp++; if (a0_q[s_rd+16] != 64 || a0_q[s_rd+23] != 71) begin n_bad++; $display("FAIL ovf_base: got %0d..%0d want 64..71", a0_q[s_rd+16], a0_q[s_rd+23]); end
        end
    endtask

    task automatic test_empty;
        int s_rd = rdc_q.size(), s_wr = wrc_q.size(), s_pe = pe_any;
        set_prog(5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_early: done %b want 0", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: done %b want 1", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL empty_err_clr: err %b want 0", err); end
        n_cmp++; if (rdc_q.size() != s_rd || wrc_q.size() != s_wr || pe_any != s_pe) begin n_bad++; $display("FAIL empty_quiet: rd %0d wr %0d pe %0d want 0 0 0", rdc_q.size() - s_rd, wrc_q.size() - s_wr, pe_any - s_pe); end
    endtask

    task automatic test_k1;
        int s_rd = rdc_q.size(), s_wr = wrc_q.size(), s_pe6 = pe6_n;
        set_prog(5'd1, 5'd0, 5'd0, 5'd0);
        pulse_start();
        wait_done("k1");
        n_cmp++; if (rdc_q.size() - s_rd != 1 || pe6_n - s_pe6 != 1) begin n_bad++; $display("FAIL k1_len: feed %0d pe6 %0d want 1 1", rdc_q.size() - s_rd, pe6_n - s_pe6); end
        else begin
            n_cmp++; if (wrc_q.size() - s_wr != 1 || wrc_q[s_wr] - rdc_q[s_rd] != 8) begin n_bad++; $display("FAIL k1_drain: wr %0d lat %0d want 1 8", wrc_q.size() - s_wr, wrc_q[wrc_q.size()-1] - rdc_q[s_rd]); end
        end
    endtask

    task automatic test_rst_mid;
        int s_wr = wrc_q.size();
        bit hit = 0;
        set_prog(5'd4, 5'd0, 5'd0, 5'd0);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en && a_addr[AW-1:0] == 7'd2) begin hit = 1; break; end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_reach: feed cycle 2 not seen"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rd_en, c_wr_en, busy, done, err, pe_clr} !== 6'b000001 || pe_en !== '0 || a_addr !== {N*AW{1'b1}} || instr_addr !== 4'd0) begin
            n_bad++; $display("FAIL rstmid_vals: flags %b pe_en %h a %h pc %0d want 000001 0 all-ones 0", {rd_en, c_wr_en, busy, done, err, pe_clr}, pe_en, a_addr, instr_addr);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (wrc_q.size() != s_wr || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort: wr %0d busy %b want 0 0", wrc_q.size() - s_wr, busy); end
    endtask

    task automatic test_start_in_drain;
        int exp_a0[6] = '{0, 1, 2, 3, 16, 17};
        int s_rd = rdc_q.size(), s_wr = wrc_q.size();
        bit hit = 0;
        set_prog(5'd4, 5'd2, 5'd0, 5'd0);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && !rd_en && pe_en != '0) begin hit = 1; break; end
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL drain_reach: drain not seen"); end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("drain");
        n_cmp++; if (wrc_q.size() - s_wr != 2 || rdc_q.size() - s_rd != 6) begin n_bad++; $display("FAIL drain_counts: wr %0d feed %0d want 2 6", wrc_q.size() - s_wr, rdc_q.size() - s_rd); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (a0_q[s_rd+i] != exp_a0[i]) begin n_bad++; $display("FAIL drain_a0[%0d]: got %0d want %0d", i, a0_q[s_rd+i], exp_a0[i]); end
            end
        end
    endtask

    task automatic test_pc_wrap;
        int s_wr = wrc_q.size();
        for (int i = 0; i < 16; i++) prog[i] = 5'd1;
        pulse_start();
        wait_done("wrap");
        n_cmp++; if (wrc_q.size() - s_wr != 16) begin n_bad++; $display("FAIL wrap_jobs: got %0d want 16", wrc_q.size() - s_wr); end
        n_cmp++; if (instr_addr !== 4'd15 || err !== 1'b0) begin n_bad++; $display("FAIL wrap_end: pc %0d err %b want 15 0", instr_addr, err); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 5'd0;
        test_reset();
        test_single();
        test_two_jobs();
        test_overflow();
        test_empty();
        test_k1();
        test_rst_mid();
        test_start_in_drain();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
